sti_dac_gen: RTL and testbench

- Parametrised serial-transmit / data-array controller, successor of the fixed 16-bit/8-bit STI-DAC block.
- Captures one DW-bit input word per load and frames it to DW/2, DW, 3DW/2 or 2DW bits with optional zero fill.
- Shifts the frame out serially, one bit per clock, and packs the same bit stream into PW-bit pixels written to a DEPTH-entry pixel memory.
- On end, pads the last partial pixel, zero-fills the remaining memory, then flags finish.
- Adds over the fixed block: busy handshake, registered mode capture, pixel bit-order mode, partial-pixel flush and overflow flag.

---
 rtl/sti_dac_gen.sv | 209 ++++++++++++++++++++
 tb/tb_sti_dac_gen.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sti_dac_gen.sv
// Frames a DW-bit word to DW/2..2DW bits, shifts it out serially and packs the stream into PW-bit pixels.
// Latency: first serial bit and any pixel write it completes appear the cycle after load is accepted.
// Backpressure: none; load is accepted only when busy=0, and loads seen while busy are dropped.
module sti_dac_gen #(
    parameter int DW    = 16,
    parameter int PW    = 8,
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [DW-1:0] pi_data,
    input  logic [1:0]    pi_length,
    input  logic          pi_fill,
    input  logic          pi_msb,
    input  logic          pi_low,
    input  logic          pi_pmsb,
    input  logic          pi_end,
    output logic          busy,
    output logic          so_data,
    output logic          so_valid,
    output logic          pixel_wr,
    output logic [AW-1:0] pixel_addr,
    output logic [PW-1:0] pixel_dataout,
    output logic          pixel_finish,
    output logic          overflow
);
    localparam int FW  = 2 * DW;
    localparam int IW  = $clog2(FW);
    localparam int CW  = AW + 1;
    localparam int PCW = $clog2(PW + 1);

    typedef enum logic [2:0] {IDLE, SHIFT, FLUSH, FILL, DONE} state_t;

    state_t          state;
    logic [FW-1:0]   frame_q;
    logic [IW-1:0]   last_q;
    logic [IW-1:0]   idx;
    logic            fin_q;
    logic            msb_q;
    logic            pmsb_q;
    logic [PW-1:0]   acc;
    logic [PCW-1:0]  pcnt;
    logic [CW-1:0]   cnt;

    logic [FW-1:0]   frame_in;
    logic [IW-1:0]   last_in;
    logic [IW-1:0]   sel;
    logic            emit;
    logic            ebit;
    logic            epmsb;
    logic [PW-1:0]   acc_nxt;
    logic [PCW-1:0]  sh;
    logic [PW-1:0]   flush_dat;
    logic            pix_done;
    logic            room;

    assign busy     = (state != IDLE);
    assign room     = (cnt < CW'(DEPTH));
    assign pix_done = emit && (pcnt == PCW'(PW - 1));

    always_comb begin
        frame_in = '0;
        last_in  = '0;
        case (pi_length)
            2'd0: begin
                frame_in[DW/2-1:0] = pi_low ? pi_data[DW-1:DW/2] : pi_data[DW/2-1:0];
                last_in            = IW'(DW/2 - 1);
            end
            2'd1: begin
                frame_in[DW-1:0] = pi_data;
                last_in          = IW'(DW - 1);
            end
            2'd2: begin
                frame_in = pi_fill ? (FW'(pi_data) << (DW/2)) : FW'(pi_data);
                last_in  = IW'(3*DW/2 - 1);
            end
            default: begin
                frame_in = pi_fill ? (FW'(pi_data) << DW) : FW'(pi_data);
                last_in  = IW'(FW - 1);
            end
        endcase
    end

    // The accepting cycle emits stream bit 0 straight from the inputs so output starts one cycle after load.
    always_comb begin
        emit  = 1'b0;
        ebit  = 1'b0;
        epmsb = pmsb_q;
        sel   = '0;
        if (state == IDLE && load) begin
            emit  = 1'b1;
            epmsb = pi_pmsb;
            ebit  = pi_msb ? frame_in[last_in] : frame_in[0];
        end else if (state == SHIFT && !fin_q) begin
            emit = 1'b1;
            sel  = msb_q ? (last_q - idx) : idx;
            ebit = frame_q[sel];
        end
        acc_nxt   = epmsb ? ((acc << 1) | PW'(ebit))
                          : ((acc >> 1) | (PW'(ebit) << (PW - 1)));
        sh        = PCW'(PW) - pcnt;
        flush_dat = pmsb_q ? (acc << sh) : (acc >> sh);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            frame_q       <= '0;
            last_q        <= '0;
            idx           <= '0;
            fin_q         <= 1'b0;
            msb_q         <= 1'b0;
            pmsb_q        <= 1'b0;
            acc           <= '0;
            pcnt          <= '0;
            cnt           <= '0;
            so_data       <= 1'b0;
            so_valid      <= 1'b0;
            pixel_wr      <= 1'b0;
            pixel_addr    <= '0;
            pixel_dataout <= '0;
            pixel_finish  <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            pixel_wr <= 1'b0;
            if (emit) begin
                if (pix_done) begin
                    acc  <= '0;
                    pcnt <= '0;
                    if (room) begin
                        pixel_wr      <= 1'b1;
                        pixel_addr    <= cnt[AW-1:0];
                        pixel_dataout <= acc_nxt;
                        cnt           <= cnt + CW'(1);
                    end else begin
                        overflow <= 1'b1;
                    end
                end else begin
                    acc  <= acc_nxt;
                    pcnt <= pcnt + PCW'(1);
                end
            end

            case (state)
                IDLE: begin
                    if (load) begin
                        frame_q  <= frame_in;
                        last_q   <= last_in;
                        msb_q    <= pi_msb;
                        pmsb_q   <= pi_pmsb;
                        so_valid <= 1'b1;
                        so_data  <= ebit;
                        idx      <= IW'(1);
                        fin_q    <= (last_in == '0);
                        state    <= SHIFT;
                    end else if (pi_end) begin
                        if (pcnt != '0) begin
                            state <= FLUSH;
                        end else if (room) begin
                            state <= FILL;
                        end else begin
                            state        <= DONE;
                            pixel_finish <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (fin_q) begin
                        so_valid <= 1'b0;
                        so_data  <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        so_data <= ebit;
                        if (idx == last_q) fin_q <= 1'b1;
                        else               idx   <= idx + IW'(1);
                    end
                end
                FLUSH: begin
                    acc  <= '0;
                    pcnt <= '0;
                    if (room) begin
                        pixel_wr      <= 1'b1;
                        pixel_addr    <= cnt[AW-1:0];
                        pixel_dataout <= flush_dat;
                        cnt           <= cnt + CW'(1);
                        state         <= (cnt == CW'(DEPTH - 1)) ? DONE : FILL;
                    end else begin
                        overflow     <= 1'b1;
                        pixel_finish <= 1'b1;
                        state        <= DONE;
                    end
                end
                FILL: begin
                    pixel_wr      <= 1'b1;
                    pixel_addr    <= cnt[AW-1:0];
                    pixel_dataout <= '0;
                    cnt           <= cnt + CW'(1);
                    if (cnt == CW'(DEPTH - 1)) state <= DONE;
                end
                default: begin
                    // Finish rises on the cycle after the final write, then holds until reset.
                    pixel_finish <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sti_dac_gen.sv
// Bench for sti_dac_gen with a non-dividing pixel width and a small memory so flush, fill and overflow all occur.
module tb_sti_dac_gen;
    localparam int DW    = 16;
    localparam int PW    = 6;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          reset, load, pi_fill, pi_msb, pi_low, pi_pmsb, pi_end;
    logic [DW-1:0] pi_data;
    logic [1:0]    pi_length;
    logic          busy, so_data, so_valid, pixel_wr, pixel_finish, overflow;
    logic [AW-1:0] pixel_addr;
    logic [PW-1:0] pixel_dataout;

    always #5 clk = ~clk;

    sti_dac_gen #(.DW(DW), .PW(PW), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset), .load(load), .pi_data(pi_data), .pi_length(pi_length),
        .pi_fill(pi_fill), .pi_msb(pi_msb), .pi_low(pi_low), .pi_pmsb(pi_pmsb), .pi_end(pi_end),
        .busy(busy), .so_data(so_data), .so_valid(so_valid), .pixel_wr(pixel_wr),
        .pixel_addr(pixel_addr), .pixel_dataout(pixel_dataout), .pixel_finish(pixel_finish),
        .overflow(overflow)
    );

    int          n_chk  = 0;
    int          n_pass = 0;
    bit          part[$];
    int          m_cnt;
    bit          m_ovf;
    bit          m_pmsb;
    logic [31:0] obs;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Pixel from the pending stream bits, missing positions read as zero.
    function automatic int pix_value(input bit first_in_msb);
        int v = 0;
        for (int i = 0; i < part.size(); i++)
            if (part[i]) v += first_in_msb ? (1 << (PW - 1 - i)) : (1 << i);
        return v;
    endfunction

    task automatic model_reset();
        part.delete();
        m_cnt = 0;
        m_ovf = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check_val(tag, {busy, so_data, so_valid, pixel_wr, pixel_finish, overflow, pixel_addr, pixel_dataout}, 32'h0);
    endtask

    task automatic restart();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_zero("reset_outputs");
        model_reset();
        load = 1'b0;
        pi_end = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic idle_cycle();
        load = 1'b0;
        pi_end = 1'b0;
        tick();
        check_val("idle_valid", so_valid, 0);
        check_val("idle_busy", busy, 0);
        check_val("idle_wr", pixel_wr, 0);
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input int len, input bit fill, input bit msb,
                              input bit low, input bit pmsb, input int abort_at);
        logic [63:0] v;
        int          n;
        bit          b;
        bit          exp_wr;
        int          exp_addr, exp_dat;
        n = (len + 1) * (DW / 2);
        case (len)
            0:       v = low ? 64'(d >> (DW / 2)) : 64'(d % (1 << (DW / 2)));
            1:       v = 64'(d);
            2:       v = fill ? (64'(d) << (DW / 2)) : 64'(d);
            default: v = fill ? (64'(d) << DW) : 64'(d);
        endcase
        pi_data = d; pi_length = 2'(len); pi_fill = fill; pi_msb = msb; pi_low = low; pi_pmsb = pmsb;
        load = 1'b1;
        pi_end = 1'($urandom_range(0, 1));
        obs = '0;
        m_pmsb = pmsb;
        tick();
        for (int k = 0; k < n; k++) begin
            b = v[msb ? (n - 1 - k) : k];
            part.push_back(b);
            exp_wr = 1'b0;
            exp_addr = 0;
            exp_dat = 0;
            if (part.size() == PW) begin
                if (m_cnt < DEPTH) begin
                    exp_wr = 1'b1;
                    exp_addr = m_cnt;
                    exp_dat = pix_value(m_pmsb);
                    m_cnt++;
                end else begin
                    m_ovf = 1'b1;
                end
                part.delete();
            end
            obs = {obs[30:0], so_data};
            check_val("so_valid", so_valid, 1);
            check_val("so_data", so_data, b);
            check_val("shift_busy", busy, 1);
            check_val("shift_wr", pixel_wr, exp_wr);
            check_val("overflow", overflow, m_ovf);
            if (exp_wr) begin
                check_val("pix_addr", pixel_addr, exp_addr);
                check_val("pix_data", pixel_dataout, exp_dat);
            end
            if (k == abort_at) begin
                #2;
                reset = 1'b0;
                #1;
                check_zero("abort_outputs");
                model_reset();
                load = 1'b0;
                pi_end = 1'b0;
                return;
            end
            load = 1'($urandom_range(0, 1));
            pi_end = 1'($urandom_range(0, 1));
            pi_data = DW'($urandom);
            pi_length = 2'($urandom_range(0, 3));
            pi_msb = 1'($urandom_range(0, 1));
            pi_pmsb = 1'($urandom_range(0, 1));
            tick();
        end
        load = 1'b0;
        pi_end = 1'b0;
        check_val("gap_valid", so_valid, 0);
        check_val("gap_busy", busy, 0);
        check_val("gap_wr", pixel_wr, 0);
    endtask

    task automatic do_end();
        bit has_part, full, wrote;
        int fv;
        has_part = part.size() > 0;
        full = (m_cnt >= DEPTH);
        wrote = 1'b0;
        load = 1'b0;
        pi_end = 1'b1;
        tick();
        pi_end = 1'b0;
        check_val("end_wr", pixel_wr, 0);
        check_val("end_busy", busy, 1);
        check_val("end_finish", pixel_finish, !has_part && full);
        if (has_part) begin
            fv = pix_value(m_pmsb);
            part.delete();
            tick();
            if (!full) begin
                check_val("flush_wr", pixel_wr, 1);
                check_val("flush_addr", pixel_addr, m_cnt);
                check_val("flush_data", pixel_dataout, fv);
                check_val("flush_finish", pixel_finish, 0);
                m_cnt++;
                wrote = 1'b1;
            end else begin
                m_ovf = 1'b1;
                check_val("flush_full_wr", pixel_wr, 0);
                check_val("flush_full_fin", pixel_finish, 1);
            end
        end
        while (m_cnt < DEPTH) begin
            tick();
            check_val("fill_wr", pixel_wr, 1);
            check_val("fill_addr", pixel_addr, m_cnt);
            check_val("fill_data", pixel_dataout, 0);
            check_val("fill_finish", pixel_finish, 0);
            m_cnt++;
            wrote = 1'b1;
        end
        if (wrote) begin
            tick();
            check_val("finish_after_write", pixel_finish, 1);
            check_val("finish_wr", pixel_wr, 0);
        end
        for (int i = 0; i < 3; i++) begin
            load = 1'($urandom_range(0, 1));
            pi_end = 1'($urandom_range(0, 1));
            tick();
            check_val("done_busy", busy, 1);
            check_val("done_valid", so_valid, 0);
            check_val("done_wr", pixel_wr, 0);
            check_val("done_finish", pixel_finish, 1);
            check_val("done_overflow", overflow, m_ovf);
        end
        load = 1'b0;
        pi_end = 1'b0;
    endtask

    initial begin
        int nf, len, ab;
        bit aborted, pm;
        reset = 1'b0; load = 1'b0; pi_data = '0; pi_length = '0; pi_fill = 1'b0;
        pi_msb = 1'b0; pi_low = 1'b0; pi_pmsb = 1'b0; pi_end = 1'b0;
        model_reset();
        #2;
        check_zero("reset_state");
        @(negedge clk);
        reset = 1'b1;

        send_frame(16'hA5C3, 1, 1'b0, 1'b1, 1'b0, 1'b1, -1);
        check_val("a5c3_stream", obs, 32'hA5C3);
        do_end();
        restart();

        send_frame(16'h1200, 0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
        check_val("low_lsb_stream", obs, 32'h48);
        restart();

        send_frame(16'hFFFF, 1, 1'b0, 1'b1, 1'b0, 1'b1, -1);
        do_end();
        restart();

        for (int s = 0; s < 40; s++) begin
            nf = $urandom_range(0, 4);
            aborted = 1'b0;
            for (int f = 0; f < nf && !aborted; f++) begin
                for (int g = $urandom_range(0, 2); g > 0; g--) idle_cycle();
                len = $urandom_range(0, 3);
                ab = ($urandom_range(0, 5) == 0) ? $urandom_range(0, (len + 1) * (DW / 2) - 1) : -1;
                pm = (part.size() == 0) ? 1'($urandom_range(0, 1)) : m_pmsb;
                send_frame(DW'($urandom), len, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)), pm, ab);
                if (ab >= 0) aborted = 1'b1;
            end
            if (!aborted) do_end();
            restart();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
